// File: rtl/reg_file_multi.sv
// Parametrised register file with byte-enable writes, optional zero register and
// write-to-read bypass, plus a sequenced CLEAR sweep with busy/done handshake.
module reg_file_multi #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                WRITE,
    input  logic [ADDR_W-1:0]   INADDRESS,
    input  logic [DATA_W-1:0]   IN,
    input  logic [DATA_W/8-1:0] BYTEEN,
    input  logic [ADDR_W-1:0]   OUT1ADDRESS,
    input  logic [ADDR_W-1:0]   OUT2ADDRESS,
    output logic [DATA_W-1:0]   OUT1,
    output logic [DATA_W-1:0]   OUT2,
    input  logic                CLEAR_REQ,
    output logic                CLEAR_BUSY,
    output logic                CLEAR_DONE,
    output logic                WRITE_DROP
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                        state;
    logic [ADDR_W:0]               cnt;
    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [DATA_W-1:0]             cur;
    logic [DATA_W-1:0]             merged;
    logic                          wr_ok;
    logic [1:0][ADDR_W-1:0]        raddr;
    logic [1:0][DATA_W-1:0]        rdata;

    // Writes only land while idle; zero-register writes vanish silently.
    assign wr_ok = WRITE && (state == IDLE) && !((ZERO_REG != 0) && (INADDRESS == '0));
    assign cur   = regs[INADDRESS];

    always_comb begin
        merged = cur;
        for (int k = 0; k < NB; k++)
            if (BYTEEN[k])
                merged[8*k +: 8] = IN[8*k +: 8];
    end

    assign raddr[0] = OUT1ADDRESS;
    assign raddr[1] = OUT2ADDRESS;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rdata[p] = ((BYPASS != 0) && wr_ok && (INADDRESS == raddr[p])) ? merged :
                          ((ZERO_REG != 0) && (raddr[p] == '0))               ? '0     :
                          regs[raddr[p]];
    end

    assign OUT1 = rdata[0];
    assign OUT2 = rdata[1];

    // Storage: the sweep owns the array while active, so it never races a write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            regs <= '0;
        else if (state == SWEEP)
            regs[cnt[ADDR_W-1:0]] <= '0;
        else if (wr_ok)
            regs[INADDRESS] <= merged;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            CLEAR_BUSY <= 1'b0;
            CLEAR_DONE <= 1'b0;
            WRITE_DROP <= 1'b0;
        end else begin
            WRITE_DROP <= WRITE && (state != IDLE);
            case (state)
                IDLE: begin
                    CLEAR_DONE <= 1'b0;
                    if (CLEAR_REQ) begin
                        state      <= SWEEP;
                        cnt        <= '0;
                        CLEAR_BUSY <= 1'b1;
                    end
                end
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        CLEAR_BUSY <= 1'b0;
                        CLEAR_DONE <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    CLEAR_DONE <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    CLEAR_BUSY <= 1'b0;
                    CLEAR_DONE <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_multi.sv
`timescale 1ns/1ps
module tb_reg_file_multi;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;
    logic [3:0]  BYTEEN;
    logic [4:0]  OUT1ADDRESS;
    logic [4:0]  OUT2ADDRESS;
    logic        CLEAR_REQ;
    logic [31:0] OUT1, OUT2, NOUT1, NOUT2;
    logic        CLEAR_BUSY, CLEAR_DONE, WRITE_DROP;
    logic        NBUSY, NDONE, NDROP;

    always #5 CLK = ~CLK;

    reg_file_multi #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .BYTEEN(BYTEEN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(OUT1), .OUT2(OUT2), .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY),
        .CLEAR_DONE(CLEAR_DONE), .WRITE_DROP(WRITE_DROP));

    reg_file_multi #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .BYTEEN(BYTEEN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(NOUT1), .OUT2(NOUT2), .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(NBUSY),
        .CLEAR_DONE(NDONE), .WRITE_DROP(NDROP));

    localparam int S_OUT1 = 0, S_OUT2 = 1, S_BUSY = 2, S_DONE = 3, S_DROP = 4,
                   S_NOUT1 = 5, S_NOUT2 = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    function automatic void chk(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_OUT1:  act = OUT1;
                S_OUT2:  act = OUT2;
                S_BUSY:  act = {31'b0, CLEAR_BUSY};
                S_DONE:  act = {31'b0, CLEAR_DONE};
                S_DROP:  act = {31'b0, WRITE_DROP};
                S_NOUT1: act = NOUT1;
                S_NOUT2: act = NOUT2;
                default: act = 'x;
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        WRITE = 1'b1; INADDRESS = a; IN = d; BYTEEN = be;
        tick();
        WRITE = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        RESET = 1'b1; WRITE = 1'b0; INADDRESS = '0; IN = '0; BYTEEN = '0;
        OUT1ADDRESS = '0; OUT2ADDRESS = '0; CLEAR_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("rst_busy", S_BUSY, 0); chk("rst_done", S_DONE, 0); chk("rst_drop", S_DROP, 0);
        tick();

        wr(5'd3, 32'h12345678, 4'hF);
        OUT1ADDRESS = 5'd3;
        chk("pre_rst_rd3", S_OUT1, 32'h12345678);
        tick();
        RESET = 1'b1;
        chk("async_rst_rd3", S_OUT1, 0);
        chk("async_rst_busy", S_BUSY, 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            OUT1ADDRESS = 5'(i); OUT2ADDRESS = 5'(31 - i);
            chk("rst_out1", S_OUT1, 0); chk("rst_out2", S_OUT2, 0);
            tick();
        end
        RESET = 1'b0;

        wr(5'd5, 32'h11223344, 4'hF);
        WRITE = 1'b1; INADDRESS = 5'd5; IN = 32'hAABBCCDD; BYTEEN = 4'b0101;
        OUT1ADDRESS = 5'd5; OUT2ADDRESS = 5'd0;
        chk("byte_bypass", S_OUT1, 32'h11BB33DD);
        chk("byte_nobypass_old", S_NOUT1, 32'h11223344);
        chk("byte_port2_zero", S_OUT2, 0);
        tick();
        WRITE = 1'b0;
        chk("byte_after", S_OUT1, 32'h11BB33DD);
        chk("byte_after_nb", S_NOUT1, 32'h11BB33DD);
        tick();

        WRITE = 1'b1; INADDRESS = 5'd7; IN = 32'hDEADBEEF; BYTEEN = 4'hF;
        OUT1ADDRESS = 5'd7; OUT2ADDRESS = 5'd7;
        chk("byp_out1", S_OUT1, 32'hDEADBEEF); chk("byp_out2", S_OUT2, 32'hDEADBEEF);
        chk("nbyp_out1_old", S_NOUT1, 0); chk("nbyp_out2_old", S_NOUT2, 0);
        tick();
        WRITE = 1'b0;
        chk("nbyp_out1_new", S_NOUT1, 32'hDEADBEEF); chk("nbyp_out2_new", S_NOUT2, 32'hDEADBEEF);
        chk("byp_out1_new", S_OUT1, 32'hDEADBEEF);
        tick();

        WRITE = 1'b1; INADDRESS = 5'd0; IN = 32'hFFFFFFFF; BYTEEN = 4'hF;
        OUT1ADDRESS = 5'd0; OUT2ADDRESS = 5'd0;
        chk("zero_byp1", S_OUT1, 0); chk("zero_byp2", S_OUT2, 0); chk("zero_nb", S_NOUT1, 0);
        tick();
        WRITE = 1'b0;
        chk("zero_after", S_OUT1, 0); chk("zero_drop", S_DROP, 0);
        tick();

        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i), 4'hF);
        OUT1ADDRESS = 5'd31; OUT2ADDRESS = 5'd0;
        chk("fill_31", S_OUT1, 32'd31); chk("fill_0", S_OUT2, 0);
        tick();
        CLEAR_REQ = 1'b1; WRITE = 1'b1; INADDRESS = 5'd9; IN = 32'h99; BYTEEN = 4'hF;
        chk("req_busy0", S_BUSY, 0);
        tick();
        CLEAR_REQ = 1'b0; WRITE = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            OUT1ADDRESS = 5'd31;
            OUT2ADDRESS = (c == 1) ? 5'd9 : 5'd20;
            WRITE = (c == 10); INADDRESS = 5'd31; IN = 32'hFFFFFFFF;
            chk("sw_busy", S_BUSY, 32'(c <= 32));
            chk("sw_done", S_DONE, 32'(c == 33));
            chk("sw_drop", S_DROP, 32'(c == 11));
            chk("sw_rd31", S_OUT1, (c >= 33) ? 32'd0 : 32'd31);
            chk("sw_rd31_nb", S_NOUT1, (c >= 33) ? 32'd0 : 32'd31);
            if (c == 1) chk("sw_rd9", S_OUT2, 32'h99);
            else        chk("sw_rd20", S_OUT2, (c >= 22) ? 32'd0 : 32'd20);
            tick();
        end
        WRITE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            OUT1ADDRESS = 5'(i);
            chk("post_sweep_rd", S_OUT1, 0);
            tick();
        end

        wr(5'd30, 32'h30, 4'hF);
        CLEAR_REQ = 1'b1;
        tick();
        CLEAR_REQ = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            chk("abort_busy", S_BUSY, 1);
            tick();
        end
        RESET = 1'b1; OUT1ADDRESS = 5'd30;
        chk("abort_rd30", S_OUT1, 0); chk("abort_busy0", S_BUSY, 0); chk("abort_done0", S_DONE, 0);
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("abort_no_done", S_DONE, 0); chk("abort_idle", S_BUSY, 0);
            tick();
        end

        CLEAR_REQ = 1'b1;
        tick();
        for (int c = 1; c <= 35; c++) begin
            chk("full_busy", S_BUSY, 32'(c <= 32 || c == 35));
            chk("full_done", S_DONE, 32'(c == 33));
            tick();
        end
        CLEAR_REQ = 1'b0; RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        OUT1ADDRESS = 5'd30;
        #1;
        if (CLEAR_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL end_busy: got %b, expected 0", CLEAR_BUSY);
        end
        if (CLEAR_DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL end_done: got %b, expected 0", CLEAR_DONE);
        end
        if (WRITE_DROP !== 1'b0) begin
            miscompares++;
            $display("FAIL end_drop: got %b, expected 0", WRITE_DROP);
        end
        if (OUT1 !== 32'h0) begin
            miscompares++;
            $display("FAIL end_rd30: got %h, expected 0", OUT1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0 || vectors == 0) $display("FAIL: %0d miscompares", miscompares);
        else                                   $display("PASS");
        $finish;
    end
endmodule
